// File: rtl/seq_impl_checker.sv
// seq_impl_checker: one-shot hardware checker for the property
// "ante[*ANT_LEN] then, DELAY cycles later, cons[*CON_LEN]".
// Handshake: start is accepted on any rising edge where the FSM is idle, and
// the done cycle counts as idle. Each accepted start produces exactly one done
// pulse, with exactly one of pass/fail/vacuous set, unless rst abandons the
// attempt first.
module seq_impl_checker #(
  parameter int ANT_LEN = 2,
  parameter int CON_LEN = 2,
  parameter int DELAY   = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             followed_by,
  input  logic             ante,
  input  logic             cons,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             vacuous,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt,
  output logic [1:0]       dbg_state
);

  localparam int MAX_A = (ANT_LEN > CON_LEN) ? ANT_LEN : CON_LEN;
  localparam int MAX_V = (MAX_A > DELAY) ? MAX_A : DELAY;
  localparam int CW    = (MAX_V < 2) ? 1 : $clog2(MAX_V + 1);

  localparam logic [CW-1:0] ANT_LAST = CW'(ANT_LEN - 1);
  localparam logic [CW-1:0] CON_LAST = CW'(CON_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((DELAY >= 2) ? (DELAY - 2) : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ANTE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_CONS = 2'd3;

  logic [1:0]    state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          fb_q;

  logic          ante_phase;
  logic [CW-1:0] ante_idx;
  logic          eff_fb;
  logic          dec, r_pass, r_fail, r_vac;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Next-state and verdict decode; the start edge in IDLE is itself antecedent sample 0.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    dec        = 1'b0;
    r_pass     = 1'b0;
    r_fail     = 1'b0;
    r_vac      = 1'b0;
    ante_phase = 1'b0;
    ante_idx   = cnt;
    eff_fb     = (state == S_IDLE) ? followed_by : fb_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          ante_phase = 1'b1;
          ante_idx   = '0;
        end
      end
      S_ANTE: ante_phase = 1'b1;
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          nxt_state = S_CONS;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      S_CONS: begin
        if (!cons) begin
          dec    = 1'b1;
          r_fail = 1'b1;
        end else if (cnt == CON_LAST) begin
          dec    = 1'b1;
          r_pass = 1'b1;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    if (ante_phase) begin
      if (!ante) begin
        // An antecedent miss decides immediately; cons is not looked at.
        dec    = 1'b1;
        r_fail = eff_fb;
        r_vac  = !eff_fb;
      end else if (ante_idx == ANT_LAST) begin
        if (DELAY == 0) begin
          // Overlapping form: this edge is also consequent sample 0.
          if (!cons) begin
            dec    = 1'b1;
            r_fail = 1'b1;
          end else if (CON_LEN == 1) begin
            dec    = 1'b1;
            r_pass = 1'b1;
          end else begin
            nxt_state = S_CONS;
            nxt_cnt   = CNT_ONE;
          end
        end else if (DELAY == 1) begin
          nxt_state = S_CONS;
          nxt_cnt   = '0;
        end else begin
          nxt_state = S_GAP;
          nxt_cnt   = '0;
        end
      end else begin
        nxt_state = S_ANTE;
        nxt_cnt   = ante_idx + CNT_ONE;
      end
    end

    if (dec) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
    end
  end

  // FSM, latched mode, registered verdict pulse and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      fb_q     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      vacuous  <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      vac_cnt  <= '0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      done    <= dec;
      pass    <= r_pass;
      fail    <= r_fail;
      vacuous <= r_vac;
      if (state == S_IDLE && start) fb_q <= followed_by;
      if (r_pass && pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
      if (r_fail && fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
      if (r_vac  && vac_cnt  != {CNT_W{1'b1}}) vac_cnt  <= vac_cnt  + 1'b1;
    end
  end

endmodule

// File: doc/seq_impl_checker.md
Name: seq_impl_checker

Overview:
- Synthesizable one-shot checker for the implication property "ante[*ANT_LEN] then, DELAY cycles later, cons[*CON_LEN]".
- Sits downstream of the reset/clock-enable stimulus: consumes the sampled `ante` and `cons` (reset and clock-enable) streams and reports pass, fail or vacuous in hardware.
- Mirrors the four property forms: `|->`/`#-#` at DELAY=0 and `|=>`/`#=#` at DELAY=1, selected per attempt by the followed-by mode.
- Keeps saturating result counters for regression dashboards.

Parameters:
- ANT_LEN, 2: consecutive antecedent cycles required. Minimum 1.
- CON_LEN, 2: consecutive consequent cycles required. Minimum 1.
- DELAY, 1: cycles from the last antecedent sample to the first consequent sample. 0 means overlapping. Range 0..15.
- CNT_W, 8: width of each result counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins one attempt when sampled high while idle.
- followed_by  in  1  latched at start. 1 = followed-by semantics (antecedent miss is a fail); 0 = implication (antecedent miss is vacuous).
- ante  in  1  antecedent signal being checked.
- cons  in  1  consequent signal being checked.
- busy  out  1  attempt in progress.
- done  out  1  one-cycle pulse when the result is valid.
- pass  out  1  result qualifier, valid with done.
- fail  out  1  result qualifier, valid with done.
- vacuous  out  1  result qualifier, valid with done.
- pass_cnt  out  CNT_W  saturating count of passes.
- fail_cnt  out  CNT_W  saturating count of fails.
- vac_cnt  out  CNT_W  saturating count of vacuous results.

Behaviour:
- Reset: rst sampled high at a posedge returns the FSM to IDLE and clears all outputs and counters to 0. This includes reset mid-attempt: the attempt is abandoned with no done pulse.
- FSM states: IDLE, ANTE, GAP, CONS.
- Edge numbering: start sampled high in IDLE at edge k.
  - ante is checked at edges k..k+ANT_LEN-1; edge k itself is the first antecedent sample.
  - cons is checked at edges k+ANT_LEN-1+DELAY .. k+ANT_LEN-2+DELAY+CON_LEN.
  - DELAY=0: the last ante edge also checks cons (overlap).
  - DELAY>=1: GAP lasts DELAY-1 cycles with no checks.
- busy: high from the cycle after edge k until done.
- Antecedent miss: ante low at any antecedent edge ends the attempt at that edge.
  - Result is vacuous (followed_by=0) or fail (followed_by=1).
  - Consequent is not examined, even at an overlapping edge.
- Consequent failure: cons low at any consequent edge ends the attempt with fail at that edge (early failure, no further sampling).
- Pass: all antecedent and consequent samples high.
- Result timing:
  - done plus exactly one of pass/fail/vacuous are registered, high for the single cycle after the deciding edge.
  - busy drops in that same cycle.
  - Otherwise pass, fail and vacuous are 0.
- Counters: increment in the done cycle and hold at all-ones (no wrap).
- start handling:
  - Ignored while busy.
  - Accepted in the done cycle, so back-to-back attempts are allowed.
  - start held high retriggers every attempt.
- Internal counters are sized for max(ANT_LEN, CON_LEN, DELAY).

Test Plan:
- Defaults; start at edge 0; ante=0 throughout; followed_by=0 -> done+vacuous after edge 0; vac_cnt=1; busy never high.
- Same stimulus with followed_by=1 -> done+fail after edge 0; fail_cnt=1.
- Defaults; ante=1 at edges 0-1, cons=1 at edges 2-3 -> done+pass after edge 3; pass_cnt=1. Repeat with cons=0 at edge 3 -> fail after edge 3.
- DELAY=0; ante=1 at edges 0-1, cons=1 at edges 1-2 -> pass after edge 2. Then cons=0 at edge 1 -> fail after edge 1.
- Defaults; ante=1 at edges 0-1, rst=1 at edge 2 -> no done; all counters 0; busy=0 after edge 2; new start at edge 4 is accepted.
- CNT_W=2; start held high with a passing stream for 5 attempts -> pass_cnt sticks at 3; one done pulse per attempt, each pulse in the same cycle as the next acceptance.
